// File: rtl/multi_pwm_generator.sv
// multi_pwm_generator: phase-locked multi-channel PWM with edge/center modes and
// shadowed parameters that are applied only at frame boundaries.
module multi_pwm_generator #(
  parameter int WIDTH          = 8,
  parameter int CHANNELS       = 4,
  parameter int INITIAL_PERIOD = 255,
  parameter int INITIAL_DUTY   = 0,
  parameter int INITIAL_CENTER = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        update_parameters,
  input  logic [WIDTH-1:0]            pwm_period,
  input  logic [CHANNELS*WIDTH-1:0]   pwm_duty_cycle,
  input  logic                        center_aligned,
  output logic [CHANNELS-1:0]         pwm,
  output logic                        period_end,
  output logic                        update_pending,
  output logic                        update_rejected
);
  localparam logic [WIDTH-1:0] INIT_P = WIDTH'(INITIAL_PERIOD);
  localparam logic [WIDTH-1:0] INIT_D = WIDTH'(INITIAL_DUTY > INITIAL_PERIOD ? INITIAL_PERIOD : INITIAL_DUTY);
  localparam logic             INIT_C = INITIAL_CENTER != 0;
  logic [WIDTH-1:0]          r_period, r_s_period, r_cnt, w_p, w_cnt_nxt;
  logic [CHANNELS*WIDTH-1:0] r_duty, r_s_duty, w_req_duty, w_d;
  logic                      r_center, r_s_center, r_dir, w_c, w_acc, w_bnd;
  logic                      w_top, w_hold, w_last, w_dir_nxt;
  logic [CHANNELS-1:0]       w_pwm;
  assign w_acc = update_parameters && pwm_period != '0;
  // r_cnt/r_dir is the position the next edge displays; on a boundary it is
  // always 0/up, so new parameters start cleanly at k = 0
  assign w_bnd = period_end;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_req_duty[c*WIDTH +: WIDTH] = pwm_duty_cycle[c*WIDTH +: WIDTH] > pwm_period ?
                                          pwm_period : pwm_duty_cycle[c*WIDTH +: WIDTH];
    assign w_pwm[c] = w_c ? r_cnt >= w_p - w_d[c*WIDTH +: WIDTH] : r_cnt < w_d[c*WIDTH +: WIDTH];
  end
  always_comb begin
    w_p       = w_bnd ? (w_acc ? pwm_period : r_s_period) : r_period;
    w_d       = w_bnd ? (w_acc ? w_req_duty : r_s_duty) : r_duty;
    w_c       = w_bnd ? (w_acc ? center_aligned : r_s_center) : r_center;
    w_top     = r_cnt == w_p - WIDTH'(1);
    w_last    = w_c ? r_dir && r_cnt == '0 : w_top;
    w_hold    = w_c && (r_dir ? r_cnt == '0 : w_top);
    w_dir_nxt = w_c && (r_dir ? r_cnt != '0 : w_top);
    w_cnt_nxt = w_hold ? r_cnt : (!w_c && w_top) ? '0 : r_dir ? r_cnt - WIDTH'(1) : r_cnt + WIDTH'(1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period        <= INIT_P;
      r_duty          <= {CHANNELS{INIT_D}};
      r_center        <= INIT_C;
      r_s_period      <= INIT_P;
      r_s_duty        <= {CHANNELS{INIT_D}};
      r_s_center      <= INIT_C;
      r_cnt           <= '0;
      r_dir           <= 1'b0;
      pwm             <= '0;
      period_end      <= 1'b0;
      update_pending  <= 1'b0;
      update_rejected <= 1'b0;
    end else begin
      if (w_acc) begin
        r_s_period <= pwm_period;
        r_s_duty   <= w_req_duty;
        r_s_center <= center_aligned;
      end
      r_period        <= w_p;
      r_duty          <= w_d;
      r_center        <= w_c;
      r_cnt           <= w_cnt_nxt;
      r_dir           <= w_dir_nxt;
      pwm             <= w_pwm;
      period_end      <= w_last;
      update_pending  <= !w_bnd && (w_acc || update_pending);
      update_rejected <= update_parameters && pwm_period == '0;
    end
  end
endmodule

// File: tb/tb_multi_pwm_generator.sv
// tb_multi_pwm_generator: vector table + cycle scoreboard against a frame-position
// reference model, plus directed multi-cycle sequences.
module tb_multi_pwm_generator;
  localparam int W = 8, CH = 4;
  logic              clk = 1'b0, reset, upd = 1'b0, ctr = 1'b0;
  logic [W-1:0]      per = '0;
  logic [CH*W-1:0]   duty = '0;
  logic [CH-1:0]     pwm;
  logic              pe, pend, rej;
  typedef struct {
    logic [CH-1:0] pwm;
    logic          pe, pend, rej;
  } exp_t;
  typedef struct {
    logic          upd;
    logic [W-1:0]  per;
    logic [CH-1:0] pwm;
    logic          pe;
  } vec_t;
  exp_t q[$];
  vec_t vecs[16];
  int   n_chk = 0, n_fail = 0;
  int   mk, mP, sP, mD[CH], sD[CH];
  bit   mC, sC, m_pe, m_pend;
  always #5 clk = ~clk;
  multi_pwm_generator #(.WIDTH(W), .CHANNELS(CH), .INITIAL_PERIOD(8), .INITIAL_DUTY(4), .INITIAL_CENTER(0)) dut (
    .clk(clk), .reset(reset), .update_parameters(upd), .pwm_period(per), .pwm_duty_cycle(duty),
    .center_aligned(ctr), .pwm(pwm), .period_end(pe), .update_pending(pend), .update_rejected(rej)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    mk = -1; mP = 8; sP = 8; mC = 0; sC = 0; m_pe = 0; m_pend = 0;
    for (int i = 0; i < CH; i++) begin mD[i] = 4; sD[i] = 4; end
    q.delete();
  endtask
  // Expected outputs after the coming edge, derived from frame position k
  task automatic model_edge();
    exp_t e;
    int   len, cnt, d;
    bit   acc;
    acc = upd && per != 0;
    if (acc) begin
      sP = per; sC = ctr;
      for (int i = 0; i < CH; i++) begin d = duty[i*W +: W]; sD[i] = d > per ? per : d; end
    end
    if (m_pe) begin
      mP = sP; mC = sC; mD = sD; mk = 0; m_pend = 0;
    end else begin
      mk = mk + 1;
      if (acc) m_pend = 1;
    end
    len = mC ? 2 * mP : mP;
    cnt = mk < mP ? mk : 2 * mP - 1 - mk;
    for (int i = 0; i < CH; i++) e.pwm[i] = mC ? cnt >= mP - mD[i] : mk < mD[i];
    m_pe = mk == len - 1;
    e.pe = m_pe; e.pend = m_pend; e.rej = upd && per == 0;
    q.push_back(e);
  endtask
  task automatic tick();
    exp_t e;
    model_edge();
    @(posedge clk); #1;
    e = q.pop_front();
    check("sb_pwm", pwm, e.pwm);
    check("sb_period_end", pe, e.pe);
    check("sb_pending", pend, e.pend);
    check("sb_rejected", rej, e.rej);
  endtask
  task automatic req(input logic [W-1:0] p, input logic [CH*W-1:0] d, input logic c);
    upd = 1'b1; per = p; duty = d; ctr = c;
    tick();
    upd = 1'b0; per = '0; duty = '0; ctr = 1'b0;
  endtask
  task automatic run_table();
    for (int i = 0; i < 16; i++) begin
      upd = vecs[i].upd; per = vecs[i].per;
      tick();
      check($sformatf("vec%0d_pwm", i), pwm, vecs[i].pwm);
      check($sformatf("vec%0d_pe", i), pe, vecs[i].pe);
    end
    upd = 1'b0;
  endtask
  initial begin
    int       cnt[CH];
    logic [9:0] hi_all, hi_any, pe_m;
    logic [5:0] hi6, pe6;
    bit       found;
    for (int i = 0; i < 16; i++) begin
      vecs[i].upd = 1'b0; vecs[i].per = '0;
      vecs[i].pwm = (i % 8) < 4 ? 4'hF : 4'h0;
      vecs[i].pe  = (i % 8) == 7;
    end
    reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_pwm", pwm, 0);
    check("rst_pe", pe, 0);
    check("rst_pend", pend, 0);
    check("rst_rej", rej, 0);
    @(posedge clk); #1;
    model_reset();
    reset = 1'b1;
    run_table();
    // Duty extremes, requested on the boundary edge so they apply at once
    req(8, {8'd1, 8'd3, 8'd8, 8'd0}, 1'b0);
    check("bnd_upd_pending", pend, 0);
    for (int i = 0; i < CH; i++) cnt[i] = int'(pwm[i]);
    for (int k = 1; k < 8; k++) begin
      tick();
      for (int i = 0; i < CH; i++) cnt[i] += int'(pwm[i]);
    end
    check("ext_ch0", cnt[0], 0);
    check("ext_ch1", cnt[1], 8);
    check("ext_ch2", cnt[2], 3);
    check("ext_ch3", cnt[3], 1);
    // Mid-frame update: sampled at the end of k = 3
    for (int k = 0; k < 4; k++) tick();
    req(6, {4{8'd2}}, 1'b0);
    check("mid_pend_k4", pend, 1);
    for (int k = 5; k < 8; k++) begin
      tick();
      check($sformatf("mid_pend_k%0d", k), pend, 1);
      check($sformatf("mid_old_ch1_k%0d", k), pwm[1], 1);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      hi6[k] = pwm[0]; pe6[k] = pe;
    end
    check("mid_new_hi", hi6, 6'b000011);
    check("mid_new_pe", pe6, 6'b100000);
    check("mid_new_pend", pend, 0);
    // Center mode P=5 D=2 applied at the boundary
    req(5, {4{8'd2}}, 1'b1);
    hi_all[0] = &pwm; hi_any[0] = |pwm; pe_m[0] = pe;
    for (int k = 1; k < 10; k++) begin
      tick();
      hi_all[k] = &pwm; hi_any[k] = |pwm; pe_m[k] = pe;
    end
    check("ctr_hi_all", hi_all, 10'h078);
    check("ctr_hi_any", hi_any, 10'h078);
    check("ctr_pe", pe_m, 10'h200);
    // Rejected request: period 0
    req(0, {4{8'd7}}, 1'b0);
    check("rej_pulse", rej, 1);
    check("rej_pend", pend, 0);
    tick();
    check("rej_clear", rej, 0);
    for (int k = 2; k < 10; k++) tick();
    check("rej_frame_len", pe, 1);
    // Duty above period is clamped to always-high
    tick();
    req(8, {4{8'd12}}, 1'b0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      found = pe;
    end
    check("clamp_boundary_seen", found, 1);
    for (int k = 0; k < 16; k++) begin
      tick();
      check($sformatf("clamp_hi_%0d", k), pwm, 4'hF);
    end
    // Reset mid-frame with an update pending
    for (int k = 0; k < 3; k++) tick();
    req(3, {4{8'd1}}, 1'b0);
    check("pre_rst_pend", pend, 1);
    #3 reset = 1'b0;
    #1;
    check("async_rst_pwm", pwm, 0);
    check("async_rst_pe", pe, 0);
    check("async_rst_pend", pend, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b1;
    run_table();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_pwm_generator.md
# multi_pwm_generator

Multi-channel PWM generator that drives CHANNELS outputs from one shared frame counter. Each channel has its own duty cycle. The block supports edge-aligned and center-aligned modes. All new parameters are held in shadow registers and take effect only at a frame boundary, so an output never shows a truncated or glitched period. It replaces single-channel PWM generation wherever several phase-locked outputs are needed, such as LED banks and motor half-bridges.

## Interface
Parameters:
- WIDTH, 8, bit width of the period and of each duty value.
- CHANNELS, 4, number of PWM outputs.
- INITIAL_PERIOD, 255, active period after reset; legal range 1..2^WIDTH-1.
- INITIAL_DUTY, 0, active duty for every channel after reset; clamped to INITIAL_PERIOD.
- INITIAL_CENTER, 0, active mode after reset (0 = edge-aligned, 1 = center-aligned).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- update_parameters  in  1  when high at a clk edge, capture the three parameter inputs below into the shadow registers.
- pwm_period  in  WIDTH  requested period P.
- pwm_duty_cycle  in  CHANNELS*WIDTH  requested duty per channel; channel i uses bits [i*WIDTH +: WIDTH].
- center_aligned  in  1  requested mode.
- pwm  out  CHANNELS  PWM outputs, registered.
- period_end  out  1  high during the last cycle of each frame, registered.
- update_pending  out  1  shadow registers hold values not yet applied.
- update_rejected  out  1  one-cycle pulse when an update request is discarded.

## Operation
- Active registers: period P, duty D[i] per channel, mode. Shadow registers have the same fields.
- Frame position k runs 0..L-1.
  - Edge mode: L = P.
  - Center mode: L = 2P. The counter counts up 0..P-1, then down P-1..0.
- Edge mode: pwm[i] is high when k < D[i], which gives D[i] high cycles per frame.
- Center mode: pwm[i] is high when count >= P-D[i], which gives 2·D[i] high cycles per frame, symmetric about the frame midpoint.
- Duty limits:
  - D = 0 holds the output constantly low.
  - D = P holds the output constantly high, with no one-cycle dropout at frame wrap.
- Duty clamping: a captured duty greater than the captured period is stored as the period. The clamp is applied per channel at capture time.
- Rejected update: a request with pwm_period = 0 is ignored entirely. The shadow registers are unchanged, update_rejected pulses on the next cycle, and update_pending is unaffected.
- Accepted update: update_pending is high from the next cycle until the frame boundary.
- Frame boundary: this is the clk edge that ends the cycle in which period_end is high.
  - At the boundary, shadow values move to the active registers and update_pending clears.
  - The next cycle is k = 0 with the new parameters.
- Repeated requests before a boundary: the last accepted request wins.
- Simultaneous update and boundary: an update sampled on the boundary edge is applied at that same boundary. update_pending stays 0.
- Width rules:
  - The counter is WIDTH bits plus one direction bit.
  - All comparisons are unsigned.
  - No arithmetic wraps, because P-D[i] >= 0 is guaranteed by the clamp.

## Timing
- Asynchronous reset values:
  - pwm = 0, period_end = 0, update_pending = 0, update_rejected = 0.
  - Counter = 0, direction = up.
  - Active registers = INITIAL_* values; shadow registers = INITIAL_* values.
- Reset takes effect immediately, including mid-frame, and discards any pending update.
- The first clk edge after reset deasserts loads the outputs for k = 0. pwm and period_end are always aligned with the current k.
- Latency:
  - update_parameters to update_pending: 1 cycle.
  - Request to new waveform: at most L cycles after the request edge, always starting at k = 0.
- period_end is exactly one cycle wide per frame. With P = 1 in edge mode it is high every cycle.

## Test plan
- Defaults: INITIAL_PERIOD = 8, INITIAL_DUTY = 4, CHANNELS = 4, edge mode, reset released.
  - Every pwm is high at k = 0..3 and low at k = 4..7.
  - period_end is high only at k = 7, repeating every 8 cycles.
- Duty extremes: update with P = 8, duties {0, 8, 3, 1}.
  - ch0 stays constantly 0 and ch1 stays constantly 1.
  - ch2 has 3 high cycles per frame and ch3 has 1 high cycle per frame.
- Mid-frame update: request at k = 3 with P = 6, all duties 2.
  - The old waveform continues through k = 7, with update_pending high during k = 4..7.
  - The next frame is 6 cycles long with high cycles at k = 0..1.
- Center mode: P = 5, D = 2.
  - Frame is 10 cycles; pwm is high at k = 3..6.
  - period_end is high at k = 9.
- Invalid inputs:
  - Request with P = 0 produces an update_rejected pulse and leaves the waveform unchanged.
  - P = 8 with duty 12 is clamped, so the output is constantly high.
- Reset mid-frame with an update pending:
  - pwm, period_end and update_pending go to 0 immediately.
  - After release, the waveform restarts at k = 0 with the INITIAL_* values.
